// File: rtl/register_file_mp.sv
// Multi-port integer register file with an integrated pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_pending,
  input  logic [1:0]             wr_en,
  input  logic [2*AW-1:0]        wr_addr,
  input  logic [2*XLEN-1:0]      wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic                   any_pending
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs_r [DEPTH];
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] clr_s;
  logic [DEPTH-1:0] set_s;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [AW-1:0]    wa_s [2];
  logic [XLEN-1:0]  wd_s [2];
  logic [1:0]       wr_ok_s;

  // Unpack write ports; a write to x0 is dropped when it is hardwired.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wa_s[p]    = wr_addr[p*AW +: AW];
      wd_s[p]    = wr_data[p*XLEN +: XLEN];
      wr_ok_s[p] = wr_en[p] && !(ZR && (wa_s[p] == '0));
    end
  end

  // Scoreboard next state: writeback clears, issue sets, set beats clear.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      clr_s[a] = (wr_en[0] && (wa_s[0] == AW'(a))) ||
                 (wr_en[1] && (wa_s[1] == AW'(a)));
      set_s[a] = iss_en && (iss_addr == AW'(a)) && !(ZR && (a == 0));
    end
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
  end

  // Register and pending-bit storage; port 1 is issued last so it wins collisions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_r[a] <= '0;
      end
      pend_r <= '0;
    end else begin
      if (wr_ok_s[0]) begin
        regs_r[wa_s[0]] <= wd_s[0];
      end
      if (wr_ok_s[1]) begin
        regs_r[wa_s[1]] <= wd_s[1];
      end
      pend_r <= pend_nxt_s;
    end
  end

  // Combinational read ports, held at zero while reset is asserted.
  always_comb begin
    logic [AW-1:0]   ra_v;
    logic [XLEN-1:0] d_v;
    logic            p_v;
    rd_data    = '0;
    rd_pending = '0;
    ra_v       = '0;
    d_v        = '0;
    p_v        = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra_v = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok_s[1] && (wa_s[1] == ra_v)) begin
        d_v = wd_s[1];
        p_v = set_s[ra_v];
      end else if (wr_ok_s[0] && (wa_s[0] == ra_v)) begin
        d_v = wd_s[0];
        p_v = set_s[ra_v];
      end else begin
        d_v = regs_r[ra_v];
        p_v = pend_r[ra_v];
      end
`else
      d_v = regs_r[ra_v];
      p_v = pend_r[ra_v];
`endif
      rd_data[i*XLEN +: XLEN] = (rstn && !(ZR && (ra_v == '0))) ? d_v : '0;
      rd_pending[i]           = rstn && !(ZR && (ra_v == '0)) && p_v;
    end
  end

  assign any_pending = rstn && (|pend_r);

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_register_file_mp;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 64;
  localparam int NUM_RD = 4;
  localparam int AW     = 6;

  logic                   clk;
  logic                   rstn;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pending;
  logic [1:0]             wr_en;
  logic [2*AW-1:0]        wr_addr;
  logic [2*XLEN-1:0]      wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic                   any_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_regs [DEPTH];
  bit              m_pend [DEPTH];

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd0;
    logic [XLEN-1:0] wd1;
    logic            ie;
    logic [AW-1:0]   ia;
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] exp_d;
    logic            exp_p;
    logic            exp_any;
  } vec_t;

  vec_t tbl [7];

  register_file_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .any_pending(any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
  endtask

  task automatic set_rd(int i, logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] port_data(int i);
    return rd_data[i*XLEN +: XLEN];
  endfunction

  // Expected read value of address a given the current stored state and inputs.
  function automatic logic [XLEN-1:0] exp_rd(logic [AW-1:0] a);
    if (a == 6'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en[1] && wr_addr[AW +: AW] == a) return wr_data[XLEN +: XLEN];
    if (wr_en[0] && wr_addr[0 +: AW] == a) return wr_data[0 +: XLEN];
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(logic [AW-1:0] a);
    if (a == 6'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wr_en[1] && wr_addr[AW +: AW] == a) || (wr_en[0] && wr_addr[0 +: AW] == a))
      return iss_en && (iss_addr == a);
`endif
    return m_pend[a];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int a = 0; a < DEPTH; a++) r = r | m_pend[a];
    return r;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      m_regs[a] = 64'd0;
      m_pend[a] = 1'b0;
    end
  endtask

  // Apply one clock edge to the model: writes in slot order, then clears, then issue.
  task automatic model_update();
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] != 6'd0)
        m_regs[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
    for (int p = 0; p < 2; p++)
      if (wr_en[p]) m_pend[wr_addr[p*AW +: AW]] = 1'b0;
    if (iss_en && iss_addr != 6'd0) m_pend[iss_addr] = 1'b1;
  endtask

  task automatic cycle_check();
    #1;
    for (int i = 0; i < NUM_RD; i++) begin
      chk("rnd_rd_data", port_data(i), exp_rd(rd_addr[i*AW +: AW]));
      chk("rnd_rd_pending", {63'd0, rd_pending[i]}, {63'd0, exp_pend(rd_addr[i*AW +: AW])});
    end
    chk("rnd_any_pending", {63'd0, any_pending}, {63'd0, exp_any()});
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{2'b11, 6'd7,  6'd7,  64'h11,         64'h22,                1'b0, 6'd0,  6'd7,  64'h22,                1'b0, 1'b0};
    tbl[1] = '{2'b01, 6'd0,  6'd0,  64'hFFFFFFFF,   64'h0,                 1'b1, 6'd0,  6'd0,  64'h0,                 1'b0, 1'b0};
    tbl[2] = '{2'b00, 6'd0,  6'd0,  64'h0,          64'h0,                 1'b1, 6'd9,  6'd9,  64'h0,                 1'b1, 1'b1};
    tbl[3] = '{2'b01, 6'd9,  6'd0,  64'h1234,       64'h0,                 1'b0, 6'd0,  6'd9,  64'h1234,              1'b0, 1'b0};
    tbl[4] = '{2'b10, 6'd0,  6'd9,  64'h0,          64'h5678,              1'b1, 6'd9,  6'd9,  64'h5678,              1'b1, 1'b1};
    tbl[5] = '{2'b10, 6'd0,  6'd63, 64'h0,          64'h0123456789ABCDEF,  1'b0, 6'd0,  6'd63, 64'h0123456789ABCDEF,  1'b0, 1'b1};
    tbl[6] = '{2'b11, 6'd9,  6'd5,  64'h9,          64'hDEADBEEF,          1'b0, 6'd0,  6'd5,  64'hDEADBEEF,          1'b0, 1'b0};

    rstn = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    idle();
    model_reset();
    #1;
    chk("reset_rd_data", port_data(0), 64'd0);
    chk("reset_any_pending", {63'd0, any_pending}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    set_rd(0, 6'd7);
    #1;
    chk("post_reset_x7", port_data(0), 64'd0);
    chk("post_reset_pending", {60'd0, rd_pending}, 64'd0);
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      wr_en    = tbl[k].we;
      wr_addr  = {tbl[k].wa1, tbl[k].wa0};
      wr_data  = {tbl[k].wd1, tbl[k].wd0};
      iss_en   = tbl[k].ie;
      iss_addr = tbl[k].ia;
      @(posedge clk);
      model_update();
      @(negedge clk);
      idle();
      set_rd(0, tbl[k].ra);
      #1;
      chk($sformatf("vec%0d_data", k), port_data(0), tbl[k].exp_d);
      chk($sformatf("vec%0d_pend", k), {63'd0, rd_pending[0]}, {63'd0, tbl[k].exp_p});
      chk($sformatf("vec%0d_any", k), {63'd0, any_pending}, {63'd0, tbl[k].exp_any});
      @(negedge clk);
    end

    // Same-cycle write of x3 observed on port 0.
    wr_en = 2'b01;
    wr_addr[0 +: AW] = 6'd3;
    wr_data[0 +: XLEN] = 64'hA5A5A5A5;
    set_rd(0, 6'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", port_data(0), 64'hA5A5A5A5);
`else
    chk("bypass_same_cycle", port_data(0), 64'h0);
`endif
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
    #1;
    chk("bypass_next_cycle", port_data(0), 64'hA5A5A5A5);
    @(negedge clk);

    for (int i = 0; i < NUM_RD; i++) set_rd(i, 6'd63);
    #1;
    for (int i = 0; i < NUM_RD; i++)
      chk($sformatf("multi_port%0d_x63", i), port_data(i), 64'h0123456789ABCDEF);
    for (int i = 0; i < NUM_RD; i++) set_rd(i, (i % 2 == 0) ? 6'd63 : 6'd0);
    #1;
    for (int i = 0; i < NUM_RD; i++)
      chk($sformatf("wrap_port%0d", i), port_data(i), (i % 2 == 0) ? 64'h0123456789ABCDEF : 64'h0);
    @(negedge clk);

    // Mid-cycle reset with a write in flight.
    iss_en = 1'b1;
    iss_addr = 6'd12;
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
    set_rd(0, 6'd5);
    set_rd(1, 6'd12);
    #1;
    chk("pre_reset_x5", port_data(0), 64'hDEADBEEF);
    chk("pre_reset_pend12", {63'd0, rd_pending[1]}, 64'd1);
    chk("pre_reset_any", {63'd0, any_pending}, 64'd1);
    wr_en = 2'b01;
    wr_addr[0 +: AW] = 6'd5;
    wr_data[0 +: XLEN] = 64'h77;
    #2;
    rstn = 1'b0;
    #1;
    chk("reset_x5_cleared", port_data(0), 64'd0);
    chk("reset_pend_cleared", {60'd0, rd_pending}, 64'd0);
    chk("reset_any_cleared", {63'd0, any_pending}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rstn = 1'b1;
    model_reset();
    #1;
    chk("reset_write_lost", port_data(0), 64'd0);
    chk("reset_release_pend12", {63'd0, rd_pending[1]}, 64'd0);
    @(negedge clk);

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        wr_addr[p*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
        wr_data[p*XLEN +: XLEN] = {$urandom, $urandom};
      end
      wr_en    = 2'($urandom_range(0, 3));
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom_range(0, 7));
      for (int i = 0; i < NUM_RD; i++)
        set_rd(i, ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63)));
      cycle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file with an integrated pending-write scoreboard, for the pipelined and dual-issue cores.
- N combinational read ports and two synchronous write ports, with deterministic port priority.
- A per-register pending bit, set at issue and cleared at writeback, so decode can detect RAW hazards without a separate scoreboard block.
- Optional same-cycle write-to-read forwarding.

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of registers; must be a power of 2 and at least 2.
- NUM_RD, 2, number of read ports, 1..6.
- ZERO_REG, 1, when 1, register 0 is hardwired to zero and can never be pending.
- AW, localparam = $clog2(DEPTH), register address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- rd_addr  input  NUM_RD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  output  NUM_RD*XLEN  read data; port i at [i*XLEN +: XLEN].
- rd_pending  output  NUM_RD  pending bit of the register addressed on read port i.
- wr_en  input  2  write enable, one bit per write port.
- wr_addr  input  2*AW  write addresses.
- wr_data  input  2*XLEN  write data.
- iss_en  input  1  issue strobe; marks iss_addr as pending.
- iss_addr  input  AW  destination register of the instruction being issued.
- any_pending  output  1  OR of all pending bits.

Behaviour:
- Reset:
  - rstn low asynchronously clears every register to 0 and every pending bit to 0.
  - While rstn is low: rd_data = 0, rd_pending = 0, any_pending = 0.
  - Release is synchronous to the design's reset synchroniser; the first write is accepted on the first rising edge with rstn high.
- Reads:
  - Purely combinational: rd_data[i] = regs[rd_addr[i]].
  - rd_pending[i] = pend[rd_addr[i]].
  - Zero-cycle latency.
- Writes:
  - Occur on the rising clk edge when wr_en[p] = 1.
  - Both ports writing the same address in one cycle: port 1 wins (program-order-later slot).
  - Writes to address 0 are dropped when ZERO_REG = 1; address 0 is an ordinary register when ZERO_REG = 0.
- Scoreboard, updated on the rising edge:
  - Clear: pend[a] cleared for each wr_addr with wr_en set.
  - Set: iss_en sets pend[iss_addr].
  - Same address cleared and set in one cycle: set wins, because the new producer supersedes the completing one.
  - Pending bit for register 0 is never set when ZERO_REG = 1.
  - A writeback to a non-pending register is legal; it writes data and the bit stays 0.
- Register 0 reads return 0 regardless of state when ZERO_REG = 1.
- Reset asserted mid-cycle: state is cleared immediately; in-flight writes in that cycle are lost.
- Out-of-range addresses cannot occur, because DEPTH is a power of 2.

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose rd_addr matches an enabled write port in the same cycle returns that port's wr_data; port 1 is used if both match.
  - The matching rd_pending is reported as 0, unless iss_en targets the same address in that cycle.
  - Address 0 is never forwarded when ZERO_REG = 1.
- Undefined:
  - Reads return stored register contents only; write data is visible the cycle after the write edge.
  - rd_pending reflects stored bits only.

Test Plan:
- Reset: write 0xDEADBEEF to x5, then pulse rstn low mid-cycle → rd_data for x5 = 0 immediately; all pending = 0; any_pending = 0.
- Write collision: wr_en = 2'b11, both addresses = 7, data 0x11 and 0x22 → the next-cycle read of x7 = 0x22.
- Zero register (ZERO_REG = 1): write 0xFFFFFFFF to x0 and issue x0 → read x0 = 0; rd_pending = 0; any_pending = 0.
- Scoreboard:
  - iss x9 → rd_pending for x9 = 1 from the next cycle.
  - Write x9 = 0x1234 → pending = 0 next cycle; data = 0x1234.
  - iss x9 and write x9 in the same cycle → pending stays 1.
- Bypass: write x3 = 0xA5A5A5A5 while port 0 reads x3.
  - With REGFILE_BYPASS_EN: same-cycle rd_data = 0xA5A5A5A5.
  - Without it: rd_data shows the old value, and 0xA5A5A5A5 appears the next cycle.
- Multi-port: NUM_RD = 4, DEPTH = 64, XLEN = 64 → write x63 = 0x0123456789ABCDEF; all four ports read x63 and return that value; address-wrap check on x63 and x0.
